// File: rtl/hyperbus_target.sv
// HyperRAM-style HyperBus responder: oversamples hbus_clk on clk, decodes the CA phase,
// counts initial latency and serves read/write bursts from a word array or register space.
module hyperbus_target #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ADDR_BITS     = 10,
  parameter int unsigned LATENCY       = 6,
  parameter bit          FIXED_LATENCY = 1'b1,
  parameter logic [15:0] ID0           = 16'h0C81,
  parameter logic [15:0] CFG0_RST      = 16'h8F1F
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hbus_clk,
  input  logic             hbus_csn,
  input  logic             hbus_rstn,
  inout  wire  [WIDTH-1:0] hbus_dq,
  inout  wire              hbus_rwds,
  output logic [15:0]      cfg0,
  output logic             busy
);

  localparam int unsigned LAT_N = LATENCY * (FIXED_LATENCY ? 2 : 1);
  localparam int unsigned LW    = $clog2(LAT_N + 1);
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA} state_t;

  state_t state, state_next;

  logic [1:0]       ck_p, csn_p, rwds_p;
  logic [WIDTH-1:0] dq_p1, dq_p2;
  logic             ck_d, csn_d;
  logic             ck_s, csn_s, rwds_s, ev, rise, csn_fall;
  logic [WIDTH-1:0] dq_s;

  logic [39:0]          ca_sr;
  logic [47:0]          ca_next;
  logic [31:0]          ca_addr;
  logic [2:0]           byte_cnt;
  logic [LW-1:0]        lat_cnt;
  logic                 is_read, is_reg, is_lin, reg_done;
  logic [ADDR_BITS-1:0] addr, addr_inc;
  logic [WIDTH-1:0]     hi_byte, dq_o;
  logic                 hi_mask, rwds_o, dq_oe, rwds_oe;
  logic                 mem_we, reg_we;
  logic [15:0]          rd_word;
  logic [15:0]          mem [DEPTH];
  logic                 unused_ok;

  // Identical two-flop pipeline for every pin so DQ/RWDS stay aligned with the clock edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ck_p   <= 2'b00;
      csn_p  <= 2'b11;
      rwds_p <= 2'b00;
      dq_p1  <= '0;
      dq_p2  <= '0;
      ck_d   <= 1'b0;
      csn_d  <= 1'b1;
    end else begin
      ck_p   <= {ck_p[0], hbus_clk};
      csn_p  <= {csn_p[0], hbus_csn};
      rwds_p <= {rwds_p[0], hbus_rwds};
      dq_p1  <= hbus_dq;
      dq_p2  <= dq_p1;
      ck_d   <= ck_p[1];
      csn_d  <= csn_p[1];
    end
  end

  assign ck_s     = ck_p[1];
  assign csn_s    = csn_p[1];
  assign rwds_s   = rwds_p[1];
  assign dq_s     = dq_p2;
  assign ev       = ck_s ^ ck_d;
  assign rise     = ck_s & ~ck_d;
  assign csn_fall = csn_d & ~csn_s;

  assign ca_next   = {ca_sr, dq_s};
  assign ca_addr   = {ca_next[44:16], ca_next[2:0]};
  assign addr_inc  = is_lin ? addr + ADDR_BITS'(1) : {addr[ADDR_BITS-1:4], addr[3:0] + 4'd1};
  assign rd_word   = is_reg ? ((addr == '0) ? ID0 : cfg0) : mem[addr];
  assign unused_ok = ^{ca_addr[31:ADDR_BITS], ca_next[15:3]};

  assign hbus_dq   = dq_oe   ? dq_o   : {WIDTH{1'bz}};
  assign hbus_rwds = rwds_oe ? rwds_o : 1'bz;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           state <= IDLE;
    else if (!hbus_rstn) state <= IDLE;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    case (state)
      IDLE:  if (csn_fall) state_next = CA;
      CA:    if (ev && byte_cnt == 3'd5)
               state_next = (!ca_next[47] && ca_next[46]) ? WDATA : LAT;
      LAT:   if (ev && lat_cnt == LW'(LAT_N)) state_next = is_read ? RDATA : WDATA;
      WDATA: if (ev && !rise) begin
               mem_we = !is_reg;
               reg_we = is_reg && !reg_done && (addr != '0);
             end
      default: ;
    endcase
    // Deselect aborts from any state
    if (csn_s) begin
      state_next = IDLE;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dq_oe   <= 1'b0;
      rwds_oe <= 1'b0;
      busy    <= 1'b0;
      cfg0    <= CFG0_RST;
    end else if (!hbus_rstn) begin
      dq_oe   <= 1'b0;
      rwds_oe <= 1'b0;
      busy    <= 1'b0;
      cfg0    <= CFG0_RST;
    end else begin
      dq_oe   <= (state_next == RDATA);
      rwds_oe <= (state_next == CA) || (state_next == RDATA);
      busy    <= (state_next != IDLE);
      if (reg_we) begin
        if (!hi_mask) cfg0[15:8] <= hi_byte;
        if (!rwds_s)  cfg0[7:0]  <= dq_s;
      end
    end
  end

  // Transaction datapath: CA shift, latency count, burst address and read byte lanes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ca_sr    <= '0;
      byte_cnt <= '0;
      lat_cnt  <= '0;
      is_read  <= 1'b0;
      is_reg   <= 1'b0;
      is_lin   <= 1'b0;
      reg_done <= 1'b0;
      addr     <= '0;
      hi_byte  <= '0;
      hi_mask  <= 1'b0;
      dq_o     <= '0;
      rwds_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          lat_cnt  <= '0;
          reg_done <= 1'b0;
          rwds_o   <= FIXED_LATENCY;
        end
        CA: if (ev) begin
          ca_sr    <= ca_next[39:0];
          byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt == 3'd5) begin
            is_read <= ca_next[47];
            is_reg  <= ca_next[46];
            is_lin  <= ca_next[45];
            addr    <= ca_addr[ADDR_BITS-1:0];
          end
        end
        LAT: begin
          if (rise) lat_cnt <= lat_cnt + LW'(1);
          if (ev && lat_cnt == LW'(LAT_N)) rwds_o <= 1'b0;
        end
        RDATA: if (ev) begin
          if (rise) begin
            dq_o   <= rd_word[15:8];
            rwds_o <= 1'b1;
          end else begin
            dq_o   <= rd_word[7:0];
            rwds_o <= 1'b0;
            addr   <= addr_inc;
          end
        end
        WDATA: if (ev) begin
          if (rise) begin
            hi_byte <= dq_s;
            hi_mask <= rwds_s;
          end else begin
            addr     <= addr_inc;
            reg_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Word array with per-byte write masks; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (!hi_mask) mem[addr][15:8] <= hi_byte;
      if (!rwds_s)  mem[addr][7:0]  <= dq_s;
    end
  end

endmodule
